// File: rtl/bpi_pkg.sv
// Shared encodings for the BPI flash responder: command codes, status bit
// positions, read modes and command FSM states.
package bpi_pkg;

  localparam logic [7:0] CMD_READ_ARRAY  = 8'hFF;
  localparam logic [7:0] CMD_READ_STATUS = 8'h70;
  localparam logic [7:0] CMD_READ_ID     = 8'h90;
  localparam logic [7:0] CMD_CLEAR_SR    = 8'h50;
  localparam logic [7:0] CMD_PROGRAM     = 8'h40;
  localparam logic [7:0] CMD_PROGRAM_ALT = 8'h10;
  localparam logic [7:0] CMD_ERASE       = 8'h20;
  localparam logic [7:0] CMD_CONFIRM     = 8'hD0;

  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;

  typedef enum logic [1:0] {
    MODE_ARRAY,
    MODE_STATUS,
    MODE_ID
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROG_SETUP,
    ST_ERASE_SETUP,
    ST_PROGRAM,
    ST_ERASE
  } state_t;

endpackage

// File: rtl/bpi_mem_array.sv
// Single-port synchronous RAM backing the emulated flash; contents survive reset.
module bpi_mem_array #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [0:(1 << AW) - 1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bpi_flash_responder.sv
// Flash-side BPI responder: decodes CFI-style commands from strobe writes and
// answers reads from the array, status register or ID words.
module bpi_flash_responder
  import bpi_pkg::*;
#(
  parameter int          AW       = 10,
  parameter int          BLK_LOG2 = 4,
  parameter int          PROG_CYC = 16,
  parameter logic [15:0] MFG_ID   = 16'h0089,
  parameter logic [15:0] DEV_ID   = 16'h891C
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          E,
  input  logic          L,
  input  logic          G,
  input  logic          W,
  input  logic [AW-1:0] ADDR,
  input  logic [15:0]   DQ_IN,
  output logic [15:0]   DQ_OUT,
  output logic          DQ_OE,
  output logic          RDY
);

  localparam int PCW = $clog2(PROG_CYC);
  localparam int CW  = (PCW > BLK_LOG2) ? PCW : BLK_LOG2;
  localparam logic [CW-1:0] PROG_LOAD  = CW'(PROG_CYC - 1);
  localparam logic [CW-1:0] PROG_WRITE = CW'(PROG_CYC - 2);
  localparam logic [CW-1:0] ERASE_LAST = CW'((1 << BLK_LOG2) - 1);

  state_t        state, state_next;
  mode_t         mode;
  logic [AW-1:0] addr_q, op_addr, mem_addr;
  logic [15:0]   wr_data_q, op_data, mem_wdata, mem_rdata, rd_src;
  logic [CW-1:0] cnt;
  logic          wr_run_q, err_erase, err_prog, mem_we, busy;
  logic [7:0]    sr;

  wire       wr_active = E & W;
  wire       rd_active = E & G & ~W;
  wire       wr_event  = wr_run_q & ~wr_active;
  wire [7:0] cmd       = wr_data_q[7:0];

  bpi_mem_array #(.AW(AW)) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (wr_event) begin
          if (cmd == CMD_PROGRAM || cmd == CMD_PROGRAM_ALT) state_next = ST_PROG_SETUP;
          else if (cmd == CMD_ERASE)                        state_next = ST_ERASE_SETUP;
        end
      end
      ST_PROG_SETUP:  if (wr_event) state_next = ST_PROGRAM;
      ST_ERASE_SETUP: if (wr_event) state_next = (cmd == CMD_CONFIRM) ? ST_ERASE : ST_IDLE;
      ST_PROGRAM:     if (cnt == '0) state_next = ST_IDLE;
      ST_ERASE:       if (cnt == ERASE_LAST) state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
  end

  // The program AND needs the old word: read it on the first busy cycle, write on the second.
  always_comb begin
    busy      = (state == ST_PROGRAM) || (state == ST_ERASE);
    sr        = {~busy, 1'b0, err_erase, err_prog, 4'b0000};
    RDY       = sr[SR_READY];
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = 16'hFFFF;
    if (state == ST_PROGRAM) begin
      mem_addr = op_addr;
      if (cnt == PROG_WRITE) begin
        mem_we    = 1'b1;
        mem_wdata = mem_rdata & op_data;
      end
    end else if (state == ST_ERASE) begin
      mem_addr = {op_addr[AW-1:BLK_LOG2], cnt[BLK_LOG2-1:0]};
      mem_we   = 1'b1;
    end
    if (busy) rd_src = {8'h00, sr};
    else begin
      case (mode)
        MODE_STATUS: rd_src = {8'h00, sr};
        MODE_ID:     rd_src = addr_q[0] ? DEV_ID : MFG_ID;
        default:     rd_src = mem_rdata;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q    <= '0;
      wr_run_q  <= 1'b0;
      wr_data_q <= '0;
      DQ_OE     <= 1'b0;
      DQ_OUT    <= '0;
    end else begin
      if (E & L) addr_q <= ADDR;
      wr_run_q <= wr_active;
      if (wr_active) wr_data_q <= DQ_IN;
      DQ_OE <= rd_active;
      if (rd_active) DQ_OUT <= rd_src;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode      <= MODE_ARRAY;
      err_erase <= 1'b0;
      err_prog  <= 1'b0;
      cnt       <= '0;
      op_addr   <= '0;
      op_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_event) begin
            case (cmd)
              CMD_READ_ARRAY:  mode <= MODE_ARRAY;
              CMD_READ_STATUS: mode <= MODE_STATUS;
              CMD_READ_ID:     mode <= MODE_ID;
              CMD_CLEAR_SR: begin
                err_erase <= 1'b0;
                err_prog  <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_PROG_SETUP: begin
          if (wr_event) begin
            op_addr <= addr_q;
            op_data <= wr_data_q;
            cnt     <= PROG_LOAD;
            mode    <= MODE_STATUS;
          end
        end
        ST_ERASE_SETUP: begin
          if (wr_event) begin
            mode <= MODE_STATUS;
            if (cmd == CMD_CONFIRM) begin
              op_addr <= addr_q;
              cnt     <= '0;
            end else begin
              err_erase <= 1'b1;
              err_prog  <= 1'b1;
            end
          end
        end
        ST_PROGRAM: cnt <= cnt - 1'b1;
        ST_ERASE:   cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bpi_flash_responder.sv
// Self-checking bench for bpi_flash_responder: a word-level model of the array
// feeds an expected-read queue that is drained as DQ_OUT becomes valid.
module tb_bpi_flash_responder;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        E = 1'b0, L = 1'b0, G = 1'b0, W = 1'b0;
  logic [9:0]  ADDR = '0;
  logic [15:0] DQ_IN = '0;
  logic [15:0] DQ_OUT;
  logic        DQ_OE, RDY;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_mem [0:1023];

  always #5 CLK = ~CLK;

  bpi_flash_responder dut (
    .CLK(CLK), .RST_N(RST_N), .E(E), .L(L), .G(G), .W(W),
    .ADDR(ADDR), .DQ_IN(DQ_IN), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE), .RDY(RDY)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic bus_write(input logic [9:0] a, input logic [15:0] d);
    @(negedge CLK); E = 1; L = 1; G = 0; W = 0; ADDR = a;
    @(negedge CLK); L = 0; W = 1; DQ_IN = d;
    @(negedge CLK); W = 0; E = 0;
  endtask

  task automatic bus_write_data(input logic [15:0] d);
    @(negedge CLK); E = 1; L = 0; G = 0; W = 1; DQ_IN = d;
    @(negedge CLK); W = 0; E = 0;
  endtask

  // Expected value is queued as the read starts and popped on the 3rd G cycle.
  task automatic read_word(input bit latch, input logic [9:0] a, input logic [15:0] exp, input string name);
    logic [15:0] want;
    if (latch) begin
      @(negedge CLK); E = 1; L = 1; G = 0; W = 0; ADDR = a;
    end
    exp_q.push_back(exp);
    @(negedge CLK); E = 1; L = 0; G = 1; W = 0;
    @(negedge CLK);
    checks++;
    if (DQ_OE !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_oe: DQ_OE=%b required 1", name, DQ_OE);
    end
    @(negedge CLK);
    want = exp_q.pop_front();
    checks++;
    if (DQ_OUT !== want) begin
      errors++;
      $display("[TB] FAIL %s: DQ_OUT=%h required %h", name, DQ_OUT, want);
    end
    @(negedge CLK);
    checks++;
    if (DQ_OUT !== want) begin
      errors++;
      $display("[TB] FAIL %s_hold: DQ_OUT=%h required %h", name, DQ_OUT, want);
    end
    E = 0; G = 0;
  endtask

  // expect_low < 0 only requires RDY to drop (or already be low) and come back.
  task automatic wait_ready(input int expect_low, input string name);
    int  low = 0;
    bit  done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge CLK);
      if (RDY === 1'b0) low++;
      else if (low > 0) done = 1;
    end
    checks++;
    if (!done || (expect_low >= 0 && low != expect_low)) begin
      errors++;
      $display("[TB] FAIL %s: RDY low for %0d cycles (returned=%0d) required %0d", name, low, done, expect_low);
    end
  endtask

  task automatic prog_word(input logic [9:0] a, input logic [15:0] d);
    bus_write(a, 16'h0040);
    bus_write_data(d);
    wait_ready(16, "prog_busy");
    model_mem[a] = model_mem[a] & d;
  endtask

  task automatic erase_block(input logic [9:0] a);
    bus_write(a, 16'h0020);
    bus_write_data(16'h00D0);
    wait_ready(16, "erase_busy");
    for (int i = 0; i < 16; i++) model_mem[{a[9:4], 4'(i)}] = 16'hFFFF;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks += 3;
    if (DQ_OUT !== 16'h0000) begin errors++; $display("[TB] FAIL reset_dq_out: %h required 0000", DQ_OUT); end
    if (DQ_OE !== 1'b0)      begin errors++; $display("[TB] FAIL reset_dq_oe: %b required 0", DQ_OE); end
    if (RDY !== 1'b1)        begin errors++; $display("[TB] FAIL reset_rdy: %b required 1", RDY); end
    @(negedge CLK); RST_N = 1;
    for (int b = 0; b < 4; b++) erase_block(10'(b * 16));
    bus_write_data(16'h00FF);
    read_word(1, 10'h005, model_mem[5], "read_erased");
  endtask

  task automatic test_program();
    bus_write(10'h005, 16'h0040);
    bus_write_data(16'h1234);
    wait_ready(16, "prog_1234_busy");
    model_mem[5] = model_mem[5] & 16'h1234;
    read_word(0, 10'h000, 16'h0080, "status_after_prog");
    bus_write_data(16'h00FF);
    read_word(1, 10'h005, model_mem[5], "read_1234");
    bus_write(10'h005, 16'h0040);
    bus_write_data(16'hFF0F);
    model_mem[5] = model_mem[5] & 16'hFF0F;
    read_word(0, 10'h000, 16'h0000, "status_busy");
    wait_ready(-1, "reprog_done");
    read_word(0, 10'h000, 16'h0080, "status_ready");
    bus_write_data(16'h00FF);
    read_word(1, 10'h005, model_mem[5], "read_and_1204");
  endtask

  task automatic test_erase();
    prog_word(10'h00F, 16'hAAAA);
    prog_word(10'h020, 16'h5555);
    prog_word(10'h013, 16'h0000);
    prog_word(10'h01F, 16'h1234);
    erase_block(10'h013);
    bus_write_data(16'h00FF);
    read_word(1, 10'h00F, model_mem[10'h00F], "erase_below");
    read_word(1, 10'h010, model_mem[10'h010], "erase_first");
    read_word(1, 10'h013, model_mem[10'h013], "erase_mid");
    read_word(1, 10'h01F, model_mem[10'h01F], "erase_last");
    read_word(1, 10'h020, model_mem[10'h020], "erase_above");
  endtask

  task automatic test_erase_error();
    bus_write(10'h013, 16'h0020);
    bus_write_data(16'h0055);
    @(negedge CLK);
    checks++;
    if (RDY !== 1'b1) begin errors++; $display("[TB] FAIL erase_err_rdy: %b required 1", RDY); end
    read_word(0, 10'h000, 16'h00B0, "erase_err_sr");
    bus_write_data(16'h0050);
    read_word(0, 10'h000, 16'h0080, "clear_sr");
    bus_write_data(16'h00FF);
    read_word(1, 10'h013, model_mem[10'h013], "erase_err_no_erase");
  endtask

  task automatic test_read_id();
    bus_write(10'h000, 16'h0090);
    read_word(1, 10'h000, 16'h0089, "id_mfg");
    read_word(1, 10'h001, 16'h891C, "id_dev");
    bus_write_data(16'h003C);
    read_word(1, 10'h000, 16'h0089, "id_after_unknown");
    read_word(1, 10'h003, 16'h891C, "id_odd_addr");
  endtask

  task automatic test_w_dominates();
    @(negedge CLK); E = 1; L = 0; G = 1; W = 1; DQ_IN = 16'h00FF;
    @(negedge CLK);
    checks++;
    if (DQ_OE !== 1'b0) begin errors++; $display("[TB] FAIL w_dominates: DQ_OE=%b required 0", DQ_OE); end
    E = 0; G = 0; W = 0;
    read_word(1, 10'h005, model_mem[5], "array_after_w_and_g");
  endtask

  task automatic test_erase_abort();
    bit seen = 0;
    for (int i = 0; i < 8; i++) prog_word(10'(10'h030 + i), 16'h0000);
    bus_write(10'h03A, 16'h0020);
    bus_write_data(16'h00D0);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      if (RDY === 1'b0) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL abort_start: RDY stayed %b required 0", RDY); end
    repeat (5) @(posedge CLK);
    @(negedge CLK); RST_N = 0;
    #1;
    checks += 3;
    if (RDY !== 1'b1)        begin errors++; $display("[TB] FAIL abort_rdy: %b required 1", RDY); end
    if (DQ_OE !== 1'b0)      begin errors++; $display("[TB] FAIL abort_oe: %b required 0", DQ_OE); end
    if (DQ_OUT !== 16'h0000) begin errors++; $display("[TB] FAIL abort_dq: %h required 0000", DQ_OUT); end
    @(negedge CLK); RST_N = 1;
    for (int i = 0; i < 5; i++) model_mem[10'(10'h030 + i)] = 16'hFFFF;
    read_word(1, 10'h030, model_mem[10'h030], "abort_word0");
    read_word(1, 10'h034, model_mem[10'h034], "abort_word4");
    read_word(1, 10'h035, model_mem[10'h035], "abort_word5");
    read_word(1, 10'h037, model_mem[10'h037], "abort_word7");
    read_word(1, 10'h038, model_mem[10'h038], "abort_word8");
    bus_write_data(16'h0070);
    read_word(0, 10'h000, 16'h0080, "abort_sr");
  endtask

  initial begin
    test_reset();
    test_program();
    test_erase();
    test_erase_error();
    test_read_id();
    test_w_dominates();
    test_erase_abort();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
